// File: rtl/instruction_fetch_pkg.sv
// Shared widths and opcode constants for the instruction fetch stage.
// The instruction word is {opcode, register select, data/immediate}.
// The opcode is the top ADDR_WIDTH bits of the word.
package instruction_fetch_pkg;

  localparam int ADDR_WIDTH    = 5;
  localparam int REG_BIT_CNT   = 3;
  localparam int DATA_WIDTH    = 16;
  localparam int COMBINED_DATA = ADDR_WIDTH + REG_BIT_CNT + DATA_WIDTH;
  localparam int PC_WIDTH      = 8;

  localparam logic [ADDR_WIDTH-1:0] OP_NOP = 5'd0;
  localparam logic [ADDR_WIDTH-1:0] OP_RST = 5'd1;
  localparam logic [ADDR_WIDTH-1:0] OP_ST  = 5'd3;

  function automatic logic [ADDR_WIDTH-1:0] opcode_of(input logic [COMBINED_DATA-1:0] word);
    return word[COMBINED_DATA-1 -: ADDR_WIDTH];
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Bus bundle between the fetch stage, its instruction ROM, and the decoder.
//   master : fetch stage (drives ROM strobe/address, instruction register, status)
//   slave  : environment (ROM data, consumer ready, jump/halt controls)
interface instruction_fetch_if;
  import instruction_fetch_pkg::*;

  logic                     rom_en;
  logic [PC_WIDTH-1:0]      rom_addr;
  logic [COMBINED_DATA-1:0] rom_data;
  logic [COMBINED_DATA-1:0] instr;
  logic [PC_WIDTH-1:0]      instr_pc;
  logic                     instr_valid;
  logic                     instr_ready;
  logic                     jump_en;
  logic [PC_WIDTH-1:0]      jump_addr;
  logic                     halt;
  logic                     halted;

  modport master (
    output rom_en, rom_addr, instr, instr_pc, instr_valid, halted,
    input  rom_data, instr_ready, jump_en, jump_addr, halt
  );

  modport slave (
    input  rom_en, rom_addr, instr, instr_pc, instr_valid, halted,
    output rom_data, instr_ready, jump_en, jump_addr, halt
  );

endinterface

// File: rtl/instruction_fetch_program_counter.sv
// Program counter register.
//   clk, rst : clock, async active-high reset (pc -> 0)
//   load     : synchronous load of load_val (wins over inc)
//   load_val : value to load
//   inc      : increment by one, wrapping at 2^WIDTH
//   pc       : current count
module program_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             inc,
  output logic [WIDTH-1:0] pc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       pc <= '0;
    else if (load) pc <= load_val;
    else if (inc)  pc <= pc + WIDTH'(1);
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: reads a synchronous ROM at pc, captures the word
// into an instruction register with a valid/ready handoff to the decoder,
// and supports jump (flush/redirect) and halt from downstream.
//   clk, rst : clock, async active-high reset
//   bus      : instruction_fetch_if.master (ROM port, instruction output,
//              handshake, jump/halt controls, halted status)
//
//   state  | meaning
//   S_IDLE | out of reset, about to issue first request
//   S_REQ  | rom_en high, ROM reading pc
//   S_WAIT | ROM data arrives; captured on the edge leaving this state
//   S_HOLD | instruction presented, waiting for instr_ready
//   S_HALT | fetch stopped, waiting for a jump
module instruction_fetch
  import instruction_fetch_pkg::*;
(
  input logic                clk,
  input logic                rst,
  instruction_fetch_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_HALT = 3'd4
  } state_t;

  state_t              state, next_state;
  logic                halt_pend;
  logic [PC_WIDTH-1:0] pc;
  logic                capture;
  logic                handoff;
  logic                halt_want;

  // A jump in S_WAIT discards the in-flight ROM word.
  assign capture   = (state == S_WAIT) && !bus.jump_en;
  assign handoff   = (state == S_HOLD) && bus.instr_ready;
  assign halt_want = bus.halt || halt_pend;

  program_counter #(.WIDTH(PC_WIDTH)) u_pc (
    .clk      (clk),
    .rst      (rst),
    .load     (bus.jump_en),
    .load_val (bus.jump_addr),
    .inc      (capture),
    .pc       (pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Any path that would enter S_REQ diverts to S_HALT while a halt is wanted.
  always_comb begin
    next_state = state;
    if (bus.jump_en) begin
      next_state = bus.halt ? S_HALT : S_REQ;
    end else begin
      unique case (state)
        S_IDLE:  next_state = halt_want ? S_HALT : S_REQ;
        S_REQ:   next_state = S_WAIT;
        S_WAIT:  next_state = S_HOLD;
        S_HOLD:  if (bus.instr_ready) next_state = halt_want ? S_HALT : S_REQ;
        S_HALT:  next_state = S_HALT;
        default: next_state = S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.rom_en = (state == S_REQ);
    bus.halted = (state == S_HALT);
  end

  assign bus.rom_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.instr       <= '0;
      bus.instr_pc    <= '0;
      bus.instr_valid <= 1'b0;
      halt_pend       <= 1'b0;
    end else begin
      if (capture) begin
        bus.instr    <= bus.rom_data;
        bus.instr_pc <= pc;
      end

      if (bus.jump_en)  bus.instr_valid <= 1'b0;
      else if (capture) bus.instr_valid <= 1'b1;
      else if (handoff) bus.instr_valid <= 1'b0;

      if (bus.jump_en)
        halt_pend <= 1'b0;
      else if (state != S_HALT && next_state == S_HALT)
        halt_pend <= 1'b0;
      else if (bus.halt && state != S_HALT)
        halt_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass_cnt = 0;
  int   total    = 0;

  logic [COMBINED_DATA-1:0] rom [0:255];

  instruction_fetch_if bus ();

  instruction_fetch dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  // Synchronous ROM model: data valid the cycle after rom_en.
  always @(posedge clk) begin
    if (bus.rom_en) bus.rom_data <= rom[bus.rom_addr];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in cycle 0 (reset just released, no edge since).
  task automatic do_reset(input logic ready);
    rst = 1'b1;
    bus.instr_ready = ready;
    bus.jump_en     = 1'b0;
    bus.jump_addr   = '0;
    bus.halt        = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    total++; if (bus.instr_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.instr_valid); else pass_cnt++;
    total++; if (bus.rom_en !== 1'b0) $display("FAIL reset_rom_en got %b want 0", bus.rom_en); else pass_cnt++;
    total++; if (bus.halted !== 1'b0) $display("FAIL reset_halted got %b want 0", bus.halted); else pass_cnt++;
    total++; if (bus.instr !== 24'h000000) $display("FAIL reset_instr got %h want 000000", bus.instr); else pass_cnt++;
    total++; if (bus.rom_addr !== 8'h00) $display("FAIL reset_rom_addr got %h want 00", bus.rom_addr); else pass_cnt++;
  endtask

  task automatic test_sequence();
    logic [23:0] exp_word [0:2];
    exp_word[0] = 24'h0A0001;
    exp_word[1] = 24'h180002;
    exp_word[2] = 24'h000000;
    do_reset(1'b1);
    for (int c = 1; c <= 9; c++) begin
      step();
      total++;
      if (bus.rom_en !== (c % 3 == 1)) $display("FAIL seq_rom_en cycle %0d got %b want %b", c, bus.rom_en, (c % 3 == 1));
      else pass_cnt++;
      total++;
      if (bus.instr_valid !== (c % 3 == 0)) $display("FAIL seq_valid cycle %0d got %b want %b", c, bus.instr_valid, (c % 3 == 0));
      else pass_cnt++;
      if (c % 3 == 0) begin
        total++;
        if (bus.instr !== exp_word[c/3-1]) $display("FAIL seq_instr cycle %0d got %h want %h", c, bus.instr, exp_word[c/3-1]);
        else pass_cnt++;
        total++;
        if (bus.instr_pc !== 8'(c/3-1)) $display("FAIL seq_instr_pc cycle %0d got %h want %h", c, bus.instr_pc, 8'(c/3-1));
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset(1'b0);
    step(); step(); step();
    for (int c = 3; c <= 8; c++) begin
      total++;
      if (bus.instr_valid !== 1'b1 || bus.instr !== 24'h0A0001 || bus.instr_pc !== 8'h00)
        $display("FAIL bp_hold cycle %0d got v=%b i=%h pc=%h want v=1 i=0a0001 pc=00", c, bus.instr_valid, bus.instr, bus.instr_pc);
      else pass_cnt++;
      total++;
      if (bus.rom_en !== 1'b0) $display("FAIL bp_no_rom_en cycle %0d got %b want 0", c, bus.rom_en);
      else pass_cnt++;
      if (c < 8) step();
    end
    bus.instr_ready = 1'b1;
    step();
    total++;
    if (bus.instr_valid !== 1'b0 || bus.rom_en !== 1'b1 || bus.rom_addr !== 8'h01)
      $display("FAIL bp_resume got v=%b en=%b addr=%h want v=0 en=1 addr=01", bus.instr_valid, bus.rom_en, bus.rom_addr);
    else pass_cnt++;
  endtask

  task automatic test_jump();
    do_reset(1'b0);
    step(); step(); step();
    bus.jump_en = 1'b1;
    bus.jump_addr = 8'h40;
    step();
    bus.jump_en = 1'b0;
    bus.instr_ready = 1'b1;
    total++;
    if (bus.instr_valid !== 1'b0 || bus.rom_en !== 1'b1 || bus.rom_addr !== 8'h40)
      $display("FAIL jump_redirect got v=%b en=%b addr=%h want v=0 en=1 addr=40", bus.instr_valid, bus.rom_en, bus.rom_addr);
    else pass_cnt++;
    step();
    total++;
    if (bus.instr_valid !== 1'b0) $display("FAIL jump_no_stale_valid got %b want 0", bus.instr_valid);
    else pass_cnt++;
    step();
    total++;
    if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 8'h40 || bus.instr !== 24'hC00040)
      $display("FAIL jump_target got v=%b pc=%h i=%h want v=1 pc=40 i=c00040", bus.instr_valid, bus.instr_pc, bus.instr);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    do_reset(1'b1);
    step(); step(); step();
    bus.jump_en = 1'b1;
    bus.jump_addr = 8'hFF;
    step();
    bus.jump_en = 1'b0;
    total++;
    if (bus.rom_addr !== 8'hFF) $display("FAIL wrap_addr_ff got %h want ff", bus.rom_addr);
    else pass_cnt++;
    step(); step();
    total++;
    if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 8'hFF || bus.instr !== 24'hC000FF)
      $display("FAIL wrap_instr got v=%b pc=%h i=%h want v=1 pc=ff i=c000ff", bus.instr_valid, bus.instr_pc, bus.instr);
    else pass_cnt++;
    step();
    total++;
    if (bus.rom_en !== 1'b1 || bus.rom_addr !== 8'h00)
      $display("FAIL wrap_next_addr got en=%b addr=%h want en=1 addr=00", bus.rom_en, bus.rom_addr);
    else pass_cnt++;
  endtask

  task automatic test_halt();
    do_reset(1'b1);
    step(); step();
    bus.halt = 1'b1;
    step();
    bus.halt = 1'b0;
    total++;
    if (bus.instr_valid !== 1'b1 || bus.instr !== 24'h0A0001 || bus.halted !== 1'b0)
      $display("FAIL halt_handoff got v=%b i=%h h=%b want v=1 i=0a0001 h=0", bus.instr_valid, bus.instr, bus.halted);
    else pass_cnt++;
    for (int c = 4; c <= 8; c++) begin
      step();
      total++;
      if (bus.halted !== 1'b1 || bus.rom_en !== 1'b0 || bus.instr_valid !== 1'b0)
        $display("FAIL halt_stopped cycle %0d got h=%b en=%b v=%b want h=1 en=0 v=0", c, bus.halted, bus.rom_en, bus.instr_valid);
      else pass_cnt++;
    end
    bus.jump_en = 1'b1;
    bus.jump_addr = 8'h10;
    step();
    bus.jump_en = 1'b0;
    total++;
    if (bus.halted !== 1'b0 || bus.rom_en !== 1'b1 || bus.rom_addr !== 8'h10)
      $display("FAIL halt_resume got h=%b en=%b addr=%h want h=0 en=1 addr=10", bus.halted, bus.rom_en, bus.rom_addr);
    else pass_cnt++;
    step(); step();
    total++;
    if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 8'h10 || bus.instr !== 24'hC00010)
      $display("FAIL halt_resume_instr got v=%b pc=%h i=%h want v=1 pc=10 i=c00010", bus.instr_valid, bus.instr_pc, bus.instr);
    else pass_cnt++;
  endtask

  task automatic test_rst_mid();
    do_reset(1'b0);
    step(); step(); step(); step();
    total++;
    if (bus.instr_valid !== 1'b1) $display("FAIL rstmid_pre_valid got %b want 1", bus.instr_valid);
    else pass_cnt++;
    rst = 1'b1;
    #1;
    total++;
    if (bus.instr_valid !== 1'b0 || bus.rom_en !== 1'b0 || bus.halted !== 1'b0 || bus.instr !== 24'h000000)
      $display("FAIL rstmid_immediate got v=%b en=%b h=%b i=%h want v=0 en=0 h=0 i=000000", bus.instr_valid, bus.rom_en, bus.halted, bus.instr);
    else pass_cnt++;
    step();
    rst = 1'b0;
    bus.instr_ready = 1'b1;
    step();
    total++;
    if (bus.rom_en !== 1'b1 || bus.rom_addr !== 8'h00)
      $display("FAIL rstmid_restart got en=%b addr=%h want en=1 addr=00", bus.rom_en, bus.rom_addr);
    else pass_cnt++;
    step(); step();
    total++;
    if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 8'h00 || bus.instr !== 24'h0A0001)
      $display("FAIL rstmid_first got v=%b pc=%h i=%h want v=1 pc=00 i=0a0001", bus.instr_valid, bus.instr_pc, bus.instr);
    else pass_cnt++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 24'hC00000 | 24'(i);
    rom[0] = 24'h0A0001;
    rom[1] = 24'h180002;
    rom[2] = 24'h000000;
    bus.rom_data    = '0;
    bus.instr_ready = 1'b0;
    bus.jump_en     = 1'b0;
    bus.jump_addr   = '0;
    bus.halt        = 1'b0;

    test_reset();
    test_sequence();
    test_backpressure();
    test_jump();
    test_wrap();
    test_halt();
    test_rst_mid();

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
